param_register_bank: RTL

PARAM_REGISTER_BANK -- requirements
Module: param_register_bank

---
 rtl/param_register_bank.sv | 114 +++++++++++
 1 files changed

// File: rtl/param_register_bank.sv
// param_register_bank: NREG registers of WIDTH bits, each updated by a shared
// FunSel operation when its enable bit is set, with two combinational read ports
// and a sticky per-register wrap flag.
//
// Ports:
//   Clock          rising-edge clock
//   Reset          asynchronous active-low reset (clears registers and Wrap)
//   I              data input for load and byte operations
//   E              per-register enable mask
//   FunSel         operation applied to every enabled register
//   OutASel/OutBSel read-port selects (a select >= NREG reads 0)
//   OutA/OutB      combinational read data
//   Wrap           sticky per-register wrap flags (registered)
module param_register_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 4,
  localparam int unsigned SW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [NREG-1:0]  E,
  input  logic [3:0]       FunSel,
  input  logic [SW-1:0]    OutASel,
  input  logic [SW-1:0]    OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [NREG-1:0]  Wrap
);

  typedef enum logic [3:0] {
    FS_DEC   = 4'b0000,
    FS_INC   = 4'b0001,
    FS_LOAD  = 4'b0010,
    FS_CLR   = 4'b0011,
    FS_LDB0  = 4'b0100,
    FS_SETB0 = 4'b0101,
    FS_SETB1 = 4'b0110,
    FS_LDSX  = 4'b0111,
    FS_SHL   = 4'b1000,
    FS_SHR   = 4'b1001,
    FS_ASR   = 4'b1010,
    FS_ROL   = 4'b1011,
    FS_ROR   = 4'b1100
  } fun_e;

  logic [WIDTH-1:0] regs    [NREG];
  logic [WIDTH-1:0] reg_nxt [NREG];
  logic [NREG-1:0]  wrap_q;
  logic [NREG-1:0]  wrap_nxt;
  fun_e             op;

  assign op = fun_e'(FunSel);

  // Next-state for every register; reserved codes fall through to hold.
  always_comb begin
    wrap_nxt = wrap_q;
    for (int k = 0; k < int'(NREG); k++) begin
      reg_nxt[k] = regs[k];
      if (E[k]) begin
        case (op)
          FS_DEC: begin
            reg_nxt[k] = regs[k] - WIDTH'(1);
            if (regs[k] == '0) wrap_nxt[k] = 1'b1;
          end
          FS_INC: begin
            reg_nxt[k] = regs[k] + WIDTH'(1);
            if (&regs[k]) wrap_nxt[k] = 1'b1;
          end
          FS_LOAD: begin
            reg_nxt[k]  = I;
            wrap_nxt[k] = 1'b0;
          end
          FS_CLR: begin
            reg_nxt[k]  = '0;
            wrap_nxt[k] = 1'b0;
          end
          FS_LDB0:  reg_nxt[k]       = WIDTH'(I[7:0]);
          FS_SETB0: reg_nxt[k][7:0]  = I[7:0];
          FS_SETB1: reg_nxt[k][15:8] = I[7:0];
          FS_LDSX:  reg_nxt[k]       = {{(WIDTH-8){I[7]}}, I[7:0]};
          FS_SHL:   reg_nxt[k]       = {regs[k][WIDTH-2:0], 1'b0};
          FS_SHR:   reg_nxt[k]       = {1'b0, regs[k][WIDTH-1:1]};
          FS_ASR:   reg_nxt[k]       = {regs[k][WIDTH-1], regs[k][WIDTH-1:1]};
          FS_ROL:   reg_nxt[k]       = {regs[k][WIDTH-2:0], regs[k][WIDTH-1]};
          FS_ROR:   reg_nxt[k]       = {regs[k][0], regs[k][WIDTH-1:1]};
          default: ;
        endcase
      end
    end
  end

  // Register and wrap-flag state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < int'(NREG); k++) regs[k] <= '0;
      wrap_q <= '0;
    end else begin
      for (int k = 0; k < int'(NREG); k++) regs[k] <= reg_nxt[k];
      wrap_q <= wrap_nxt;
    end
  end

  // Read ports: no bypass, out-of-range selects read 0.
  always_comb begin
    OutA = '0;
    OutB = '0;
    if (32'(OutASel) < NREG) OutA = regs[OutASel];
    if (32'(OutBSel) < NREG) OutB = regs[OutBSel];
  end

  assign Wrap = wrap_q;

endmodule
